// File: rtl/uart_autobaud_ctrl.sv
// UART auto-baud controller: times the start bit of a 0x55 sync char and selects baud_sel.
// Optional macro AUTOBAUD_VERIFY_EN re-measures the next low pulse and requires the same code.
module uart_autobaud_ctrl #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [3:0]  DEFAULT_SEL    = 4'd9
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rx,
  input  logic       start,
  input  logic       manual_en,
  input  logic [3:0] manual_sel,
  output logic [3:0] baud_sel,
  output logic       locked,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CW       = 32;
  localparam int unsigned SW       = 4;
  localparam logic [SW-1:0] LAST_SEL = SW'(12);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_HI,
    WAIT_FALL,
    MEASURE,
    SEARCH,
`ifdef AUTOBAUD_VERIFY_EN
    V_WAIT_FALL,
    V_MEASURE,
`endif
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] cnt;
  logic [SW-1:0] idx;
  logic [SW-1:0] k_sel;
  logic [SW-1:0] cmp_sel_c;
  logic          hit_c;
  logic          timeout_c;

  // Nominal bit period in clk cycles for each baud code.
  function automatic logic [CW-1:0] bit_period(input logic [SW-1:0] k);
    case (k)
      4'd0:    bit_period = CW'(CLK_FREQ / 1200);
      4'd1:    bit_period = CW'(CLK_FREQ / 2400);
      4'd2:    bit_period = CW'(CLK_FREQ / 4800);
      4'd3:    bit_period = CW'(CLK_FREQ / 9600);
      4'd4:    bit_period = CW'(CLK_FREQ / 19200);
      4'd5:    bit_period = CW'(CLK_FREQ / 28800);
      4'd6:    bit_period = CW'(CLK_FREQ / 38400);
      4'd7:    bit_period = CW'(CLK_FREQ / 57600);
      4'd8:    bit_period = CW'(CLK_FREQ / 76800);
      4'd9:    bit_period = CW'(CLK_FREQ / 115200);
      4'd10:   bit_period = CW'(CLK_FREQ / 230400);
      4'd11:   bit_period = CW'(CLK_FREQ / 460800);
      4'd12:   bit_period = CW'(CLK_FREQ / 921600);
      default: bit_period = '0;
    endcase
  endfunction

  // +/-12.5% acceptance window around the nominal period.
  function automatic logic window_hit(input logic [CW-1:0] c, input logic [SW-1:0] k);
    logic [CW-1:0] p;
    logic [CW-1:0] tol;
    p   = bit_period(k);
    tol = p >> 3;
    window_hit = (c >= p - tol) && (c <= p + tol);
  endfunction

  always_comb begin
    cmp_sel_c = idx;
`ifdef AUTOBAUD_VERIFY_EN
    if (state != SEARCH) cmp_sel_c = k_sel;
`endif
    hit_c     = window_hit(cnt, cmp_sel_c);
    timeout_c = (cnt + CW'(1)) >= CW'(TIMEOUT_CYCLES);
  end

  // Two-flop synchroniser for the asynchronous rx pad.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      k_sel    <= '0;
      baud_sel <= DEFAULT_SEL;
      locked   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (manual_en) begin
        // Manual override wins over any run in progress.
        state <= IDLE;
        busy  <= 1'b0;
        if (manual_sel <= LAST_SEL) begin
          baud_sel <= manual_sel;
          locked   <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= WAIT_HI;
              busy  <= 1'b1;
              error <= 1'b0;
              cnt   <= '0;
            end
          end
          WAIT_HI: begin
            if (rx_sync) begin
              state <= WAIT_FALL;
              cnt   <= '0;
            end else if (timeout_c) begin
              state <= ERR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          WAIT_FALL: begin
            if (!rx_sync) begin
              state <= MEASURE;
              cnt   <= CW'(1);
            end else if (timeout_c) begin
              state <= ERR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          MEASURE: begin
            if (rx_sync) begin
              state <= SEARCH;
              idx   <= '0;
            end else if (timeout_c) begin
              state <= ERR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SEARCH: begin
            if (hit_c) begin
              k_sel <= idx;
`ifdef AUTOBAUD_VERIFY_EN
              state <= V_WAIT_FALL;
              cnt   <= '0;
`else
              state <= DONE;
`endif
            end else if (idx == LAST_SEL) begin
              state <= ERR;
            end else begin
              idx <= idx + SW'(1);
            end
          end
`ifdef AUTOBAUD_VERIFY_EN
          V_WAIT_FALL: begin
            if (!rx_sync) begin
              state <= V_MEASURE;
              cnt   <= CW'(1);
            end else if (timeout_c) begin
              state <= ERR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          V_MEASURE: begin
            if (rx_sync) begin
              state <= hit_c ? DONE : ERR;
            end else if (timeout_c) begin
              state <= ERR;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`endif
          DONE: begin
            baud_sel <= k_sel;
            locked   <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          ERR: begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
